// File: rtl/mmu_seq.sv
// Command sequencer for the SIZE x SIZE matrix-multiply unit: queues LOAD/MULT/SWAP
// commands and drives the mmu handshakes in order, with MULT repeats, overlapped load and abort.
module mmu_seq #(
  parameter int unsigned SIZE      = 64,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              cmd_ovl,
  input  logic              cmd_push,
  output logic              cmd_rdy,
  input  logic              abort,
  input  logic              weight_ld_rdy,
  output logic              weight_ld_start,
  input  logic              weight_ld_done,
  output logic              weight_swap,
  input  logic              mult_rdy,
  output logic              mult_start,
  input  logic              mult_done,
  output logic              busy,
  output logic              cmd_done,
  output logic              err,
  input  logic              err_clr,
  output logic [PERF_W-1:0] perf_busy_cyc
);
  // SIZE is only forwarded to the array; folding it in here keeps it referenced.
  localparam int unsigned QD = (SIZE > 0) ? CMD_DEPTH : 2;
  localparam int unsigned PW = $clog2(QD);

  localparam logic [1:0] OP_NOP = 2'd0, OP_LD = 2'd1, OP_MUL = 2'd2;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             ovl;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, MUL_ISSUE, MUL_WAIT, SWAP, RETIRE} state_e;

  cmd_t             q_mem [QD];
  cmd_t             head;
  logic [PW-1:0]    wp_q, rp_q;
  logic [PW:0]      cnt_q;
  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic             ovl_q, ovl_iss_q;
  logic             ld_out_q, mul_out_q, ld_orph_q, mul_orph_q;
  logic             ld_start_q, mul_start_q, swap_q, done_q, err_q;
  logic [PERF_W-1:0] perf_q;
  logic             push_ok, pop;
  logic             ld_done_orph, ld_done_ok, mul_done_orph, mul_done_ok, err_set;

  assign head    = q_mem[rp_q];
  // A full queue still accepts a push in a cycle where IDLE pops the head.
  assign cmd_rdy = (cnt_q != (PW+1)'(QD)) || (state_q == IDLE);
  assign busy    = (cnt_q != '0) || (state_q != IDLE);
  assign push_ok = cmd_push && cmd_rdy && !abort;
  assign pop     = (state_q == IDLE) && (cnt_q != '0) && !abort;

  // Done pulses go first to a pre-abort orphan, then to the live command, else flag err.
  assign ld_done_orph  = weight_ld_done && ld_orph_q;
  assign ld_done_ok    = weight_ld_done && !ld_orph_q && ld_out_q;
  assign mul_done_orph = mult_done && mul_orph_q;
  assign mul_done_ok   = mult_done && !mul_orph_q && mul_out_q;
  assign err_set = (weight_ld_done && !ld_orph_q && !ld_out_q) ||
                   (mult_done && !mul_orph_q && !mul_out_q);

  assign weight_ld_start = ld_start_q;
  assign mult_start      = mul_start_q;
  assign weight_swap     = swap_q;
  assign cmd_done        = done_q;
  assign err             = err_q;
  assign perf_busy_cyc   = perf_q;

  always_ff @(posedge clk) begin
    if (push_ok) q_mem[wp_q] <= {cmd_op, cmd_cnt, cmd_ovl};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0; rp_q <= '0; cnt_q <= '0;
      state_q <= IDLE; rem_q <= '0; ovl_q <= 1'b0; ovl_iss_q <= 1'b0;
      ld_out_q <= 1'b0; mul_out_q <= 1'b0; ld_orph_q <= 1'b0; mul_orph_q <= 1'b0;
      ld_start_q <= 1'b0; mul_start_q <= 1'b0; swap_q <= 1'b0; done_q <= 1'b0;
      err_q <= 1'b0; perf_q <= '0;
    end else begin
      ld_start_q <= 1'b0; mul_start_q <= 1'b0; swap_q <= 1'b0; done_q <= 1'b0;
      if (err_set) err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      if (busy && perf_q != '1) perf_q <= perf_q + 1'b1;

      if (ld_done_orph)  ld_orph_q  <= 1'b0;
      if (ld_done_ok)    ld_out_q   <= 1'b0;
      if (mul_done_orph) mul_orph_q <= 1'b0;
      if (mul_done_ok) begin
        mul_out_q <= 1'b0;
        if (rem_q != '0) rem_q <= rem_q - 1'b1;
      end

      if (abort) begin
        wp_q <= '0; rp_q <= '0; cnt_q <= '0;
        state_q <= IDLE; rem_q <= '0; ovl_q <= 1'b0; ovl_iss_q <= 1'b0;
        ld_out_q <= 1'b0; mul_out_q <= 1'b0;
        ld_orph_q  <= (ld_orph_q && !ld_done_orph) || (ld_out_q && !ld_done_ok);
        mul_orph_q <= (mul_orph_q && !mul_done_orph) || (mul_out_q && !mul_done_ok);
      end else begin
        if (push_ok) wp_q <= wp_q + 1'b1;
        if (pop)     rp_q <= rp_q + 1'b1;
        if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push_ok) cnt_q <= cnt_q - 1'b1;

        // Overlap load is retried every MULT cycle until the mmu takes it.
        if ((state_q == MUL_ISSUE || state_q == MUL_WAIT) && ovl_q && !ovl_iss_q && weight_ld_rdy) begin
          ld_start_q <= 1'b1; ld_out_q <= 1'b1; ovl_iss_q <= 1'b1;
        end

        case (state_q)
          IDLE: if (pop) begin
            rem_q     <= (head.cnt == '0) ? CNT_W'(1) : head.cnt;
            ovl_q     <= head.ovl && (head.op == OP_MUL);
            ovl_iss_q <= 1'b0;
            case (head.op)
              OP_NOP:  state_q <= RETIRE;
              OP_LD:   state_q <= LD_ISSUE;
              OP_MUL:  state_q <= MUL_ISSUE;
              default: state_q <= SWAP;
            endcase
          end
          LD_ISSUE: if (weight_ld_rdy) begin
            ld_start_q <= 1'b1; ld_out_q <= 1'b1; state_q <= LD_WAIT;
          end
          LD_WAIT: if (ld_done_ok) state_q <= RETIRE;
          MUL_ISSUE: if (mult_rdy) begin
            mul_start_q <= 1'b1; mul_out_q <= 1'b1; state_q <= MUL_WAIT;
          end
          MUL_WAIT: begin
            if (mul_done_ok && rem_q > CNT_W'(1)) state_q <= MUL_ISSUE;
            else if (rem_q == '0 && !mul_out_q && (!ovl_q || ovl_iss_q) && !ld_out_q)
              state_q <= RETIRE;
          end
          SWAP: if (!ld_out_q) begin
            swap_q <= 1'b1; state_q <= RETIRE;
          end
          RETIRE: begin
            done_q <= 1'b1; state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
